// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the single sdram_controller request/ack port among
// NUM_PORTS requesters, with one transaction in flight and a sticky no-ack watchdog.
module sdram_port_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int FPGA_ADDR_WIDTH = 23,
  parameter int FPGA_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                 fpga_clk,
  input  logic                                 fpga_reset,
  input  logic [NUM_PORTS-1:0]                 m_req,
  input  logic [NUM_PORTS-1:0]                 m_wr_en,
  input  logic [NUM_PORTS-1:0]                 m_rd_en,
  input  logic [NUM_PORTS*FPGA_ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_PORTS*FPGA_DATA_WIDTH-1:0] m_wr_data,
  output logic [NUM_PORTS-1:0]                 m_ack,
  output logic [FPGA_DATA_WIDTH-1:0]           m_rd_data,
  output logic                                 fpga_req,
  output logic                                 fpga_wr_en,
  output logic                                 fpga_rd_en,
  output logic [FPGA_ADDR_WIDTH-1:0]           fpga_addr,
  output logic [FPGA_DATA_WIDTH-1:0]           fpga_wr_data,
  input  logic                                 fpga_ack,
  input  logic [FPGA_DATA_WIDTH-1:0]           fpga_rd_data,
  output logic                                 busy,
  output logic                                 illegal_err,
  output logic                                 timeout_err
);

  localparam int GW       = $clog2(NUM_PORTS);
  localparam int WD_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
  localparam int WDW      = $clog2(WD_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    grant;
  logic             grant_valid;
  logic [GW:0]      cand;
  logic [NUM_PORTS-1:0] eligible;
  logic [WDW-1:0]   wd_cnt;

  // Scan ports starting just after the previous winner so every requester gets a turn.
  always_comb begin
    eligible    = m_req & (m_wr_en ^ m_rd_en);
    grant       = last_grant;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = {1'b0, last_grant} + (GW+1)'(i);
      if (cand >= (GW+1)'(NUM_PORTS))
        cand = cand - (GW+1)'(NUM_PORTS);
      if (!grant_valid && eligible[cand[GW-1:0]]) begin
        grant_valid = 1'b1;
        grant       = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant_valid) state_nxt = WAIT_ACK;
      WAIT_ACK: if (fpga_ack)    state_nxt = RELEASE;
      RELEASE:                   state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk or posedge fpga_reset) begin
    if (fpga_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge fpga_clk or posedge fpga_reset) begin
    if (fpga_reset) begin
      last_grant   <= GW'(NUM_PORTS - 1);
      fpga_req     <= 1'b0;
      fpga_wr_en   <= 1'b0;
      fpga_rd_en   <= 1'b0;
      fpga_addr    <= '0;
      fpga_wr_data <= '0;
      m_ack        <= '0;
      m_rd_data    <= '0;
      wd_cnt       <= '0;
      illegal_err  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      m_ack <= '0;
      if (|(m_req & ~(m_wr_en ^ m_rd_en)))
        illegal_err <= 1'b1;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            fpga_req     <= 1'b1;
            fpga_wr_en   <= m_wr_en[grant];
            fpga_rd_en   <= m_rd_en[grant];
            fpga_addr    <= m_addr[grant*FPGA_ADDR_WIDTH +: FPGA_ADDR_WIDTH];
            fpga_wr_data <= m_wr_data[grant*FPGA_DATA_WIDTH +: FPGA_DATA_WIDTH];
            last_grant   <= grant;
            wd_cnt       <= '0;
          end
        end
        WAIT_ACK: begin
          // The watchdog only flags a stuck controller; the transaction is never aborted.
          if (wd_cnt != WDW'(WD_LIMIT))
            wd_cnt <= wd_cnt + 1'b1;
          if (TIMEOUT_CYCLES != 0 && wd_cnt == WDW'(WD_LIMIT - 1))
            timeout_err <= 1'b1;
          if (fpga_ack) begin
            fpga_req          <= 1'b0;
            fpga_wr_en        <= 1'b0;
            fpga_rd_en        <= 1'b0;
            m_ack[last_grant] <= 1'b1;
            if (fpga_rd_en)
              m_rd_data <= fpga_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: a bench-side controller model acks requests,
// and each m_ack pops the expected transaction in grant order.
module tb_sdram_port_arbiter;

  localparam int NP = 2;
  localparam int AW = 23;
  localparam int DW = 32;

  logic               fpga_clk = 1'b0;
  logic               fpga_reset;
  logic [NP-1:0]      m_req, m_wr_en, m_rd_en;
  logic [NP*AW-1:0]   m_addr;
  logic [NP*DW-1:0]   m_wr_data;
  logic [NP-1:0]      m_ack;
  logic [DW-1:0]      m_rd_data;
  logic               fpga_req, fpga_wr_en, fpga_rd_en;
  logic [AW-1:0]      fpga_addr;
  logic [DW-1:0]      fpga_wr_data;
  logic               fpga_ack;
  logic [DW-1:0]      fpga_rd_data;
  logic               busy, illegal_err, timeout_err;

  sdram_port_arbiter #(
    .NUM_PORTS(NP), .FPGA_ADDR_WIDTH(AW), .FPGA_DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .fpga_clk(fpga_clk), .fpga_reset(fpga_reset),
    .m_req(m_req), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en),
    .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_ack(m_ack), .m_rd_data(m_rd_data),
    .fpga_req(fpga_req), .fpga_wr_en(fpga_wr_en), .fpga_rd_en(fpga_rd_en),
    .fpga_addr(fpga_addr), .fpga_wr_data(fpga_wr_data),
    .fpga_ack(fpga_ack), .fpga_rd_data(fpga_rd_data),
    .busy(busy), .illegal_err(illegal_err), .timeout_err(timeout_err)
  );

  always #5 fpga_clk = ~fpga_clk;

  typedef struct {
    int            port;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t          exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            ack_delay = 5;
  bit            ctrl_on = 1'b1;
  bit            gap_mode = 1'b0;
  bit            had_pulse = 1'b0;
  bit            req_seen = 1'b0;
  bit            prev_ack = 1'b0;
  int            wait_cnt = 0;
  int            low_run = 0;
  logic [DW-1:0] last_rd = '0;
  int            req_cnt[NP];
  int            req_lim[NP];
  logic [AW-1:0] req_addr[NP];
  logic [DW-1:0] req_data[NP];

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input int p, input bit wr, input bit rd,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input int lim);
    req_cnt[p]  = 0;
    req_lim[p]  = lim;
    req_addr[p] = addr;
    req_data[p] = data;
    m_wr_en[p]  = wr;
    m_rd_en[p]  = rd;
    m_addr[p*AW +: AW]    = addr;
    m_wr_data[p*DW +: DW] = data;
    m_req[p]    = 1'b1;
  endtask

  task automatic expectTxn(input int p, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
    txn_t t;
    t.port  = p;
    t.wr    = wr;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = rdata;
    exp_q.push_back(t);
  endtask

  task automatic dropPort(input int p);
    m_req[p]   = 1'b0;
    m_wr_en[p] = 1'b0;
    m_rd_en[p] = 1'b0;
  endtask

  // One cycle: score acks, advance requesters, then play the controller side.
  task automatic tick();
    txn_t e;
    int   p;
    @(negedge fpga_clk);
    if (prev_ack) checkOutput("ack_single", m_ack, 0);
    prev_ack = |m_ack;
    if (|m_ack) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_ack", m_ack, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("ack_port", m_ack, 64'(1) << e.port);
        checkOutput("req_low_at_ack", fpga_req, 0);
        if (!e.wr) begin
          checkOutput("rd_data", m_rd_data, e.rdata);
          last_rd = e.rdata;
        end else begin
          checkOutput("rd_hold_on_wr", m_rd_data, last_rd);
        end
      end
      p = 0;
      for (int i = 0; i < NP; i++) if (m_ack[i]) p = i;
      req_cnt[p]++;
      if (req_cnt[p] < req_lim[p]) begin
        m_addr[p*AW +: AW]    = req_addr[p] + AW'(req_cnt[p]);
        m_wr_data[p*DW +: DW] = req_data[p] + DW'(req_cnt[p]);
      end else begin
        dropPort(p);
      end
    end
    fpga_ack = 1'b0;
    if (fpga_req) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        wait_cnt = 0;
        if (gap_mode && had_pulse) checkOutput("req_gap", low_run, 2);
        had_pulse = 1'b1;
        low_run   = 0;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_req", fpga_req, 0);
        end else begin
          checkOutput("fpga_addr", fpga_addr, exp_q[0].addr);
          checkOutput("fpga_wr_en", fpga_wr_en, exp_q[0].wr);
          checkOutput("fpga_rd_en", fpga_rd_en, !exp_q[0].wr);
          if (exp_q[0].wr) checkOutput("fpga_wr_data", fpga_wr_data, exp_q[0].wdata);
        end
      end
      if (ctrl_on && exp_q.size() != 0) begin
        if (wait_cnt >= ack_delay) begin
          fpga_ack     = 1'b1;
          fpga_rd_data = exp_q[0].rdata;
        end else begin
          wait_cnt++;
        end
      end
    end else begin
      req_seen = 1'b0;
      low_run++;
    end
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || fpga_req || busy) && n < max_cycles) begin
      tick();
      n++;
    end
    if (n >= max_cycles) checkOutput("drain_timeout", exp_q.size(), 0);
    tick();
  endtask

  initial begin
    fpga_reset   = 1'b1;
    m_req        = '0;
    m_wr_en      = '0;
    m_rd_en      = '0;
    m_addr       = '0;
    m_wr_data    = '0;
    fpga_ack     = 1'b0;
    fpga_rd_data = '0;
    for (int i = 0; i < NP; i++) begin
      req_cnt[i] = 0; req_lim[i] = 0; req_addr[i] = '0; req_data[i] = '0;
    end
    repeat (3) tick();
    fpga_reset = 1'b0;
    tick();
    checkOutput("rst_fpga_req", fpga_req, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_m_ack", m_ack, 0);
    checkOutput("rst_illegal", illegal_err, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    checkOutput("rst_rd_data", m_rd_data, 0);
    checkOutput("rst_fpga_addr", fpga_addr, 0);

    $display("[TB] port0 write, ack after 5 cycles");
    ack_delay = 5;
    expectTxn(0, 1'b1, {2'h0, 12'hfff, 9'h001}, 32'hff01, 32'hdead0001);
    applyStimulus(0, 1'b1, 1'b0, {2'h0, 12'hfff, 9'h001}, 32'hff01, 1);
    tick();
    checkOutput("t1_latency_req", fpga_req, 1);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_addr", fpga_addr, 23'h1ffe01);
    drain(50);

    $display("[TB] port1 read");
    expectTxn(1, 1'b0, {2'h1, 12'h5f2, 9'h0f2}, 32'h0, 32'hff02);
    applyStimulus(1, 1'b0, 1'b1, {2'h1, 12'h5f2, 9'h0f2}, 32'h0, 1);
    drain(50);
    repeat (3) tick();
    checkOutput("t2_rd_hold", m_rd_data, 32'hff02);

    $display("[TB] both ports continuous, 4 transactions");
    ack_delay = 2;
    gap_mode  = 1'b1;
    had_pulse = 1'b0;
    expectTxn(0, 1'b1, 23'h000100, 32'haaaa0000, 32'hdead0002);
    expectTxn(1, 1'b0, 23'h000200, 32'h0,        32'h11110000);
    expectTxn(0, 1'b1, 23'h000101, 32'haaaa0001, 32'hdead0003);
    expectTxn(1, 1'b0, 23'h000201, 32'h1,        32'h11110001);
    applyStimulus(0, 1'b1, 1'b0, 23'h000100, 32'haaaa0000, 2);
    applyStimulus(1, 1'b0, 1'b1, 23'h000200, 32'h0, 2);
    drain(100);
    gap_mode = 1'b0;

    $display("[TB] watchdog with silent controller");
    ctrl_on = 1'b0;
    expectTxn(0, 1'b1, 23'h000abc, 32'h44440000, 32'hdead0004);
    applyStimulus(0, 1'b1, 1'b0, 23'h000abc, 32'h44440000, 1);
    tick();
    checkOutput("t4_req", fpga_req, 1);
    repeat (14) tick();
    checkOutput("t4_err_early", timeout_err, 0);
    repeat (3) tick();
    checkOutput("t4_err_set", timeout_err, 1);
    ctrl_on   = 1'b1;
    ack_delay = 0;
    drain(50);
    checkOutput("t4_err_sticky", timeout_err, 1);

    $display("[TB] illegal port0 request alongside valid port1 write");
    checkOutput("t5_illegal_before", illegal_err, 0);
    ack_delay = 1;
    applyStimulus(0, 1'b1, 1'b1, 23'h000777, 32'h77770000, 1);
    expectTxn(1, 1'b1, 23'h000555, 32'h55550000, 32'hdead0005);
    applyStimulus(1, 1'b1, 1'b0, 23'h000555, 32'h55550000, 1);
    drain(50);
    repeat (3) tick();
    checkOutput("t5_illegal", illegal_err, 1);
    checkOutput("t5_no_req", fpga_req, 0);
    dropPort(0);
    tick();

    $display("[TB] reset during WAIT_ACK");
    ctrl_on = 1'b0;
    expectTxn(0, 1'b1, 23'h000999, 32'h99990000, 32'hdead0006);
    applyStimulus(0, 1'b1, 1'b0, 23'h000999, 32'h99990000, 1);
    tick();
    tick();
    checkOutput("t6_in_wait", busy, 1);
    #2 fpga_reset = 1'b1;
    #1;
    checkOutput("t6_rst_req", fpga_req, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_wr_en", fpga_wr_en, 0);
    checkOutput("t6_rst_addr", fpga_addr, 0);
    checkOutput("t6_rst_illegal", illegal_err, 0);
    checkOutput("t6_rst_timeout", timeout_err, 0);
    exp_q.delete();
    dropPort(0);
    last_rd = '0;
    tick();
    tick();
    fpga_reset = 1'b0;
    ctrl_on    = 1'b1;
    ack_delay  = 1;
    expectTxn(0, 1'b1, 23'h000310, 32'h31000000, 32'hdead0007);
    expectTxn(1, 1'b1, 23'h000320, 32'h32000000, 32'hdead0008);
    applyStimulus(0, 1'b1, 1'b0, 23'h000310, 32'h31000000, 1);
    applyStimulus(1, 1'b1, 1'b0, 23'h000320, 32'h32000000, 1);
    drain(60);
    checkOutput("t6_rd_data_reset", m_rd_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
